// File: rtl/bus_trace_fifo_if.sv
// Bus-side signal bundle for bus_trace_fifo: CPU bus capture inputs, pop request
// and the record/status outputs toward the SPI monitor serializer.
interface bus_trace_fifo_if;
  logic        ENABLE_IN;
  logic        AS_IN;
  logic        DTACK_IN;
  logic        WR_IN;
  logic        UDS_IN;
  logic        LDS_IN;
  logic [23:0] ADDR_IN;
  logic [15:0] DATA_IN;
  logic        RD_IN;
  logic [47:0] REC_OUT;
  logic        REC_VALID_OUT;
  logic        EMPTY_OUT;
  logic        FULL_OUT;
  logic [7:0]  DROP_CNT_OUT;

  modport master (
    output ENABLE_IN, AS_IN, DTACK_IN, WR_IN, UDS_IN, LDS_IN, ADDR_IN, DATA_IN, RD_IN,
    input  REC_OUT, REC_VALID_OUT, EMPTY_OUT, FULL_OUT, DROP_CNT_OUT
  );

  modport slave (
    input  ENABLE_IN, AS_IN, DTACK_IN, WR_IN, UDS_IN, LDS_IN, ADDR_IN, DATA_IN, RD_IN,
    output REC_OUT, REC_VALID_OUT, EMPTY_OUT, FULL_OUT, DROP_CNT_OUT
  );
endinterface

// File: rtl/bus_trace_fifo.sv
// Records one {addr, data, strobes, ovf, seq} entry per completed 68000 bus cycle
// into a small FIFO read out one record per pop by the SPI monitor path.
module bus_trace_fifo #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  bus_trace_fifo_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  logic [1:0]       r_as_sync;
  logic [1:0]       r_dtack_sync;
  logic             w_as_s;
  logic             w_dtack_s;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_capture;

  logic [47:0]      r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [3:0]       r_seq;
  logic             r_pend_ovf;
  logic [7:0]       r_drop_cnt;
  logic [47:0]      r_rec;
  logic             r_rec_valid;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_write;
  logic             w_drop;
  logic [47:0]      w_rec;

  // Two-flop synchronizers for the strobes that are asynchronous to CLK_IN.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      r_as_sync    <= 2'b00;
      r_dtack_sync <= 2'b00;
    end else begin
      r_as_sync    <= {r_as_sync[0], bus.AS_IN};
      r_dtack_sync <= {r_dtack_sync[0], bus.DTACK_IN};
    end
  end

  assign w_as_s    = r_as_sync[1];
  assign w_dtack_s = r_dtack_sync[1];

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_as_s && bus.ENABLE_IN) w_next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (w_dtack_s) begin
          w_next_state = ST_DONE;
          w_capture    = 1'b1;
        end else if (!w_as_s) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!w_as_s) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Bus fields are sampled raw: AS and DTACK are both held on the capture cycle.
  assign w_rec = {bus.ADDR_IN, bus.DATA_IN, bus.WR_IN, bus.UDS_IN, bus.LDS_IN,
                  r_pend_ovf, r_seq};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // A same-cycle pop frees the slot, so a capture while full is still accepted.
  assign w_pop   = bus.RD_IN && !w_empty;
  assign w_write = w_capture && (!w_full || w_pop);
  assign w_drop  = w_capture && w_full && !w_pop;

  // NOTE: storage has no reset; only pointers define which entries are valid.
  always_ff @(posedge CLK_IN) begin
    if (w_write) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_rec;
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_seq       <= 4'd0;
      r_pend_ovf  <= 1'b0;
      r_drop_cnt  <= 8'd0;
      r_rec       <= 48'd0;
      r_rec_valid <= 1'b0;
    end else begin
      r_rec_valid <= w_pop;
      if (w_pop) begin
        r_rec    <= r_mem[r_rd_ptr[PTR_W-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_capture) r_seq <= r_seq + 4'd1;
      if (w_write) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_pend_ovf <= 1'b0;
      end
      if (w_drop) begin
        r_pend_ovf <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign bus.REC_OUT       = r_rec;
  assign bus.REC_VALID_OUT = r_rec_valid;
  assign bus.EMPTY_OUT     = w_empty;
  assign bus.FULL_OUT      = w_full;
  assign bus.DROP_CNT_OUT  = r_drop_cnt;

endmodule

// File: tb/tb_bus_trace_fifo.sv
// Scoreboard bench for bus_trace_fifo: bus-cycle stimulus pushes expected records,
// a negedge monitor pops and compares each record the DUT presents.
module tb_bus_trace_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_trace_fifo_if bus ();

  bus_trace_fifo #(.DEPTH(DEPTH)) dut (
    .CLK_IN   (clk),
    .RESET_IN (rst),
    .bus      (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [47:0] exp_q [$];
  logic [47:0] mon_exp;
  logic [47:0] m_last_rec;
  int          m_count;
  logic [3:0]  m_seq;
  logic        m_pend;
  logic [7:0]  m_drop;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every presented record must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && bus.REC_VALID_OUT) begin
      if (exp_q.size() == 0) begin
        check("rec_valid_unexpected", 48'(bus.REC_VALID_OUT), 48'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rec", bus.REC_OUT, mon_exp);
        m_last_rec = mon_exp;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.AS_IN = 1'b0;
    bus.DTACK_IN = 1'b0;
    bus.RD_IN = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_seq = 4'd0;
    m_pend = 1'b0;
    m_drop = 8'd0;
    m_last_rec = 48'd0;
    check("rst_empty",     48'(bus.EMPTY_OUT),     48'd1);
    check("rst_full",      48'(bus.FULL_OUT),      48'd0);
    check("rst_drop_cnt",  48'(bus.DROP_CNT_OUT),  48'd0);
    check("rst_rec_valid", 48'(bus.REC_VALID_OUT), 48'd0);
    check("rst_rec_out",   bus.REC_OUT,            48'd0);
  endtask

  // One bus cycle: AS held 8 periods, DTACK raised 3 periods in when ack=1.
  // pop_at_cap asserts RD_IN exactly on the capture cycle.
  task automatic bus_cycle(input logic [23:0] a, input logic [15:0] d, input logic wr,
                           input logic ack, input logic pop_at_cap);
    logic [47:0] rec;
    if (ack && bus.ENABLE_IN) begin
      rec = {a, d, wr, 1'b1, 1'b1, m_pend, m_seq};
      m_seq = m_seq + 4'd1;
      if (m_count < DEPTH || pop_at_cap) begin
        exp_q.push_back(rec);
        m_pend = 1'b0;
        if (!(pop_at_cap && m_count > 0)) m_count++;
      end else begin
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        m_pend = 1'b1;
      end
    end else if (pop_at_cap && m_count > 0) begin
      m_count--;
    end
    @(negedge clk);
    bus.ADDR_IN = a;
    bus.DATA_IN = d;
    bus.WR_IN   = wr;
    bus.UDS_IN  = 1'b1;
    bus.LDS_IN  = 1'b1;
    bus.AS_IN   = 1'b1;
    repeat (3) @(negedge clk);
    bus.DTACK_IN = ack;
    if (pop_at_cap) begin
      repeat (2) @(negedge clk);
      bus.RD_IN = 1'b1;
      @(negedge clk);
      bus.RD_IN = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    bus.AS_IN    = 1'b0;
    bus.DTACK_IN = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_rec();
    @(negedge clk);
    bus.RD_IN = 1'b1;
    if (m_count > 0) m_count--;
    @(negedge clk);
    bus.RD_IN = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.ENABLE_IN = 1'b1;
    bus.AS_IN     = 1'b0;
    bus.DTACK_IN  = 1'b0;
    bus.WR_IN     = 1'b0;
    bus.UDS_IN    = 1'b0;
    bus.LDS_IN    = 1'b0;
    bus.ADDR_IN   = 24'd0;
    bus.DATA_IN   = 16'd0;
    bus.RD_IN     = 1'b0;
    m_last_rec    = 48'd0;

    // Three write cycles, popped back in order with SEQ 0..2.
    do_reset();
    bus_cycle(24'h000100, 16'h1111, 1'b1, 1'b1, 1'b0);
    check("empty_after_write", 48'(bus.EMPTY_OUT), 48'd0);
    bus_cycle(24'h000102, 16'h2222, 1'b1, 1'b1, 1'b0);
    bus_cycle(24'h000104, 16'h3333, 1'b1, 1'b1, 1'b0);
    repeat (3) pop_rec();
    check("empty_after_3_pops", 48'(bus.EMPTY_OUT), 48'd1);

    // Overflow: 18 captures into 16 entries, then OVF on the next stored record.
    do_reset();
    for (int i = 0; i < 18; i++)
      bus_cycle(24'h002000 + 24'(2 * i), 16'hA5A5 ^ 16'(i), 1'(i), 1'b1, 1'b0);
    check("full_after_18",  48'(bus.FULL_OUT),     48'd1);
    check("drop_after_18",  48'(bus.DROP_CNT_OUT), 48'd2);
    pop_rec();
    bus_cycle(24'h003000, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    pop_rec();
    bus_cycle(24'h003002, 16'hCAFE, 1'b1, 1'b1, 1'b0);
    repeat (DEPTH) pop_rec();
    check("empty_after_drain", 48'(bus.EMPTY_OUT),    48'd1);
    check("drop_held",         48'(bus.DROP_CNT_OUT), 48'd2);

    // Aborted cycle: no record, SEQ unchanged (next record must carry SEQ 4).
    bus_cycle(24'h004000, 16'h4444, 1'b0, 1'b0, 1'b0);
    check("empty_after_abort", 48'(bus.EMPTY_OUT), 48'd1);
    bus_cycle(24'h004002, 16'h4545, 1'b0, 1'b1, 1'b0);
    pop_rec();

    // Full plus capture and pop on the same cycle: accepted, no drop.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      bus_cycle(24'h005000 + 24'(2 * i), 16'h5000 + 16'(i), 1'b1, 1'b1, 1'b0);
    check("full_before_simul", 48'(bus.FULL_OUT), 48'd1);
    bus_cycle(24'h005100, 16'h5A5A, 1'b0, 1'b1, 1'b1);
    check("drop_after_simul", 48'(bus.DROP_CNT_OUT), 48'd0);
    check("full_after_simul", 48'(bus.FULL_OUT),     48'd1);
    repeat (DEPTH) pop_rec();
    check("empty_after_drain2", 48'(bus.EMPTY_OUT), 48'd1);

    // Read while empty is ignored; disabled capture makes no record.
    pop_rec();
    check("rd_empty_valid", 48'(bus.REC_VALID_OUT), 48'd0);
    check("rd_empty_rec",   bus.REC_OUT,            m_last_rec);
    bus.ENABLE_IN = 1'b0;
    bus_cycle(24'h006000, 16'h6666, 1'b1, 1'b1, 1'b0);
    check("empty_when_disabled", 48'(bus.EMPTY_OUT), 48'd1);
    bus.ENABLE_IN = 1'b1;
    bus_cycle(24'h006002, 16'h6767, 1'b1, 1'b1, 1'b0);
    pop_rec();

    // Reset after five stored records discards them and restarts SEQ.
    for (int i = 0; i < 5; i++)
      bus_cycle(24'h007000 + 24'(2 * i), 16'h7000 + 16'(i), 1'b0, 1'b1, 1'b0);
    check("empty_before_reset", 48'(bus.EMPTY_OUT), 48'd0);
    do_reset();
    bus_cycle(24'h008000, 16'h8888, 1'b1, 1'b1, 1'b0);
    pop_rec();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
